// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring divide, one quotient bit per cycle,
// with the divide-by-zero and signed-overflow cases resolved at accept time.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q, quo_q, divisor_q, result_q;
  logic             rem_sel_q, neg_quo_q, neg_rem_q;

  logic            accept, is_signed, div_zero, overflow, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN:0]   rem_sh, trial;
  logic [XLEN-1:0] rem_nx, quo_nx, quo_fin, rem_fin;

  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign is_signed = !op[0];
  assign div_zero  = (operand_b == '0);
  assign overflow  = is_signed && (operand_a == INT_MIN) && (operand_b == '1);
  assign special   = div_zero || overflow;

  // Negating INT_MIN wraps back to itself, which is exactly its unsigned magnitude 2^(XLEN-1).
  assign a_mag = (is_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
  assign b_mag = (is_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? operand_a : '1;
    else
      special_res = op[1] ? '0 : INT_MIN;
  end

  // One restoring step: shift {rem,quo} left, try subtracting the divisor.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign trial  = rem_sh - {1'b0, divisor_q};

  always_comb begin
    rem_nx = rem_sh[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      rem_nx = trial[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  assign quo_fin = neg_quo_q ? -quo_nx : quo_nx;
  assign rem_fin = neg_rem_q ? -rem_nx : rem_nx;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = special ? S_DONE : S_CALC;
        S_CALC:  if (cnt_q == '0) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs; flush kills a done that would otherwise be presented this cycle.
  always_comb begin
    ready = (state_q == S_IDLE);
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE) && !flush;
  end

  assign result = result_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      rem_sel_q <= op[1];
      neg_quo_q <= is_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
      neg_rem_q <= is_signed && operand_a[XLEN-1];
      divisor_q <= b_mag;
      quo_q     <= a_mag;
      rem_q     <= '0;
      cnt_q     <= CNT_W'(XLEN - 1);
      if (special)
        result_q <= special_res;
    end else if (state_q == S_CALC && !flush) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      if (cnt_q == '0)
        result_q <= rem_sel_q ? rem_fin : quo_fin;
      else
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, signed/unsigned results, special cases, flush, reset, handshake.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        ready, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in the current cycle, then scrambles the inputs and waits for done.
  // lat is the cycle (accept edge = 0) in which done was seen, -1 if it never came.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output bit busy_ok);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    step();
    start = 1'b0; op = ~o; operand_a = 32'hDEAD_BEEF; operand_b = 32'h0000_0003;
    lat = -1; res = 32'h0; busy_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
      step();
    end
    step();
    $display("op=%b a=%h b=%h -> result=%h done_cycle=%0d", o, a, b, res, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    repeat (3) step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    rst_n = 1'b1;
    step();
    $display("reset: ready=%b busy=%b done=%b result=%h", ready, busy, done, result);
  endtask

  task automatic test_normal();
    logic [1:0]  v_op [8] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10};
    logic [31:0] v_a  [8] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                              32'h8000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
    logic [31:0] v_b  [8] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                              32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    logic [31:0] v_r  [8] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                              32'hC000_0000, 32'd2, 32'hFFFF_FFFE};
    int lat; logic [31:0] res; bit bok;
    for (int i = 0; i < 8; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], lat, res, bok);
      checks++; if (res !== v_r[i]) begin errors++; $display("FAIL normal_result[%0d] got=%h exp=%h", i, res, v_r[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL normal_latency[%0d] got=%0d exp=33", i, lat); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL normal_busy[%0d] got=%b exp=1", i, bok); end
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL normal_ready_after got=%b exp=1", ready); end
  endtask

  task automatic test_special();
    logic [1:0]  v_op [6] = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01};
    logic [31:0] v_a  [6] = '{32'd5, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'h8000_0000};
    logic [31:0] v_b  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] v_r  [6] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0, 32'hFFFF_FFFB, 32'h0};
    int          v_l  [6] = '{1, 1, 1, 1, 1, 33};
    int lat; logic [31:0] res; bit bok;
    for (int i = 0; i < 6; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], lat, res, bok);
      checks++; if (res !== v_r[i]) begin errors++; $display("FAIL special_result[%0d] got=%h exp=%h", i, res, v_r[i]); end
      checks++; if (lat !== v_l[i]) begin errors++; $display("FAIL special_latency[%0d] got=%0d exp=%0d", i, lat, v_l[i]); end
    end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res; bit bok; bit saw_done;
    start = 1'b1; op = 2'b01; operand_a = 32'd100; operand_b = 32'd7;
    step();
    start = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_c10 got=%b exp=1", busy); end
    step();
    flush = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready_c11 got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done_c11 got=%b exp=0", done); end
    $display("flush at cycle 10: ready=%b busy=%b at cycle 11", ready, busy);
    run_op(2'b01, 32'd9, 32'd3, lat, res, bok);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL flush_new_result got=%h exp=3", res); end
    checks++; if (lat + 11 !== 44) begin errors++; $display("FAIL flush_new_done_cycle got=%0d exp=44", lat + 11); end

    // flush raised in the done cycle suppresses the strobe
    start = 1'b1; op = 2'b01; operand_a = 32'd9; operand_b = 32'd3;
    step();
    start = 1'b0;
    repeat (32) step();
    flush = 1'b1;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_in_done got=%b exp=0", done); end
    step();
    flush = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_after_done got=%b exp=0", done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_done_ready got=%b exp=1", ready); end
    $display("flush in done cycle: done suppressed=%b", !done);

    // flush beats start in the same cycle
    start = 1'b1; flush = 1'b1; op = 2'b01; operand_a = 32'd9; operand_b = 32'd3;
    step();
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_over_start got=%b exp=0", busy); end
    saw_done = 1'b0;
    repeat (40) begin step(); if (done) saw_done = 1'b1; end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_over_start_done got=%b exp=0", saw_done); end
    $display("flush with start: busy=%b done_seen=%b", busy, saw_done);
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    start = 1'b1; op = 2'b01; operand_a = 32'd100; operand_b = 32'd7;
    step();
    start = 1'b0;
    repeat (19) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result got=%h exp=0", result); end
    saw_done = 1'b0;
    repeat (20) begin step(); if (done) saw_done = 1'b1; end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midreset_late_done got=%b exp=0", saw_done); end
    $display("reset at cycle 20: busy=%b result=%h done_seen=%b", busy, result, saw_done);
  endtask

  task automatic test_handshake();
    int lat; logic [31:0] res; bit bok;
    start = 1'b1; op = 2'b01; operand_a = 32'd100; operand_b = 32'd7;
    step();
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      start = 1'b1; op = 2'b01; operand_a = 32'd50; operand_b = 32'd5;
      #1;
      if (done) begin lat = c; break; end
      step();
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL hs_latency got=%0d exp=33", lat); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL hs_first_result got=%h exp=14", result); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hs_ready_in_done got=%b exp=0", ready); end
    $display("start held during CALC: result=%h done_cycle=%0d", result, lat);
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL hs_ready_after got=%b exp=1", ready); end
    run_op(2'b01, 32'd50, 32'd5, lat, res, bok);
    checks++; if (res !== 32'd10) begin errors++; $display("FAIL hs_second_result got=%h exp=10", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL hs_second_latency got=%0d exp=33", lat); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_flush();
    test_reset_mid();
    test_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
